// File: rtl/spi_sd_pkg.sv
// Shared constants for the SPI-mode SD card responder: command indices,
// R1 bit positions, data token, OCR fields, FSM states and the CRC7 step.
package spi_sd_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;
  localparam logic [5:0] CMD59 = 6'd59;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC_ERR = 3;

  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [7:0] FILL_BYTE  = 8'hFF;

  // OCR below the busy/CCS bits: no UHS-II/S18A, 2.7-3.6 V window
  localparam logic [5:0] OCR_RSVD   = 6'h00;
  localparam logic [7:0] OCR_VDD_HI = 8'hFF;
  localparam logic [7:0] OCR_VDD_LO = 8'h80;
  localparam logic [7:0] OCR_LOW    = 8'h00;

  typedef enum logic [2:0] {
    S_WAIT,
    S_RX,
    S_NCR,
    S_RESP,
    S_NAC,
    S_TOK,
    S_DATA,
    S_CRC
  } state_t;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

endpackage

// File: rtl/spi_sd_crc7.sv
// Bit-serial CRC7 accumulator; clear restarts the sum and, together with
// enable, folds in the first bit of a new frame in the same cycle.
module spi_sd_crc7
  import spi_sd_pkg::*;
(
  input  logic       spi_clk_i,
  input  logic       spi_rst_i,
  input  logic       clear,
  input  logic       enable,
  input  logic       shift_bit,
  output logic [6:0] crc
);

  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      crc <= '0;
    end else if (clear) begin
      crc <= enable ? crc7_step(7'h00, shift_bit) : 7'h00;
    end else if (enable) begin
      crc <= crc7_step(crc, shift_bit);
    end
  end

endmodule

// File: rtl/spi_sd_responder.sv
// SPI-mode SD card responder: decodes 48-bit commands, answers R1/R3/R7 and
// streams CMD17 blocks. Define SPI_SD_CRC7_CHK_EN to enforce command CRC7.
module spi_sd_responder
  import spi_sd_pkg::*;
#(
  parameter int unsigned NCR_BYTES      = 1,
  parameter int unsigned NAC_BYTES      = 2,
  parameter int unsigned ACMD41_RETRIES = 2,
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter bit          HCS            = 1'b1
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic        sd_sclk_i,
  input  logic        sd_cs_n_i,
  input  logic        sd_mosi_i,
  output logic        sd_miso_o,
  input  logic [7:0]  sd_rddata_i,
  output logic        sd_rdreq_o,
  output logic [5:0]  sd_cmd_o,
  output logic [31:0] sd_arg_o,
  output logic        sd_cmdvalid_o,
  output logic        sd_idle_o,
  output logic        sd_ready_o
);

  localparam int CNT_W   = ($clog2(BLOCK_BYTES + 1) < 4) ? 4 : $clog2(BLOCK_BYTES + 1);
  localparam int RETRY_W = (ACMD41_RETRIES < 1) ? 1 : $clog2(ACMD41_RETRIES + 1);
  localparam logic [CNT_W-1:0]   NCR_LAST   = CNT_W'(NCR_BYTES - 1);
  localparam logic [CNT_W-1:0]   NAC_LAST   = CNT_W'(NAC_BYTES - 1);
  localparam logic [CNT_W-1:0]   BLK_LAST   = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [RETRY_W-1:0] RETRY_INIT = RETRY_W'(ACMD41_RETRIES);

  state_t state_q, state_next;

  logic [1:0] sclk_ff, cs_ff, mosi_ff;
  logic       sclk_d;
  logic       sclk_rise, sclk_fall, cs_hi, mosi_s;

  logic [46:0]      rx_sr;
  logic [5:0]       rx_cnt;
  logic [7:0]       tx_sr;
  logic [2:0]       tx_bit;
  logic [CNT_W-1:0] byte_cnt, byte_limit;
  logic [39:0]      resp_buf;
  logic             resp_long_q, data_phase_q, load_pending;

  logic               idle_q, ready_q, crc_on_q, app_q;
  logic [RETRY_W-1:0] retry_q;

  logic [47:0]        frame;
  logic [5:0]         f_cmd;
  logic [31:0]        f_arg;
  logic               start_det, frame_done, frame_ok, tx_state, byte_done, byte_last;
  logic               crc_err;
  logic               idle_n, ready_n, crc_on_n, app_n, data_n, long_n;
  logic [RETRY_W-1:0] retry_n;
  logic [7:0]         r1;
  logic [31:0]        trail_data;

  assign sclk_rise = sclk_ff[1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[1] & sclk_d;
  assign cs_hi     = cs_ff[1];
  assign mosi_s    = mosi_ff[1];

  assign frame      = {rx_sr, mosi_s};
  assign f_cmd      = frame[45:40];
  assign f_arg      = frame[39:8];
  assign start_det  = !cs_hi && (state_q == S_WAIT) && sclk_rise && rx_sr[0] && !mosi_s;
  assign frame_done = (state_q == S_RX) && sclk_rise && (rx_cnt == 6'd47);
  assign frame_ok   = !frame[47] && frame[46] && frame[0];
  assign tx_state   = (state_q != S_WAIT) && (state_q != S_RX);
  assign byte_done  = tx_state && sclk_fall && (tx_bit == 3'd7);
  assign byte_last  = (byte_cnt == byte_limit);

`ifdef SPI_SD_CRC7_CHK_EN
  logic [6:0] crc_calc;
  logic       crc_en;

  assign crc_en = start_det || ((state_q == S_RX) && sclk_rise && (rx_cnt <= 6'd39));

  spi_sd_crc7 u_crc7 (
    .spi_clk_i (spi_clk_i),
    .spi_rst_i (spi_rst_i),
    .clear     (start_det),
    .enable    (crc_en),
    .shift_bit (mosi_s),
    .crc       (crc_calc)
  );

  assign crc_err = ((f_cmd == CMD0) || (f_cmd == CMD8) || crc_on_q) && (crc_calc != frame[7:1]);
`else
  logic [6:0] unused_crc_bits;
  assign unused_crc_bits = frame[7:1];
  assign crc_err = 1'b0;
`endif

  // Response and next card state for the frame completing this cycle
  always_comb begin
    idle_n     = idle_q;
    ready_n    = ready_q;
    crc_on_n   = crc_on_q;
    retry_n    = retry_q;
    app_n      = 1'b0;
    data_n     = 1'b0;
    long_n     = 1'b0;
    trail_data = '0;
    r1         = '0;
    r1[R1_IDLE] = idle_q;
    if (crc_err) begin
      r1[R1_CRC_ERR] = 1'b1;
    end else begin
      case (f_cmd)
        CMD0: begin
          idle_n      = 1'b1;
          ready_n     = 1'b0;
          retry_n     = RETRY_INIT;
          crc_on_n    = 1'b0;
          r1[R1_IDLE] = 1'b1;
        end
        CMD8: begin
          long_n     = 1'b1;
          trail_data = {16'h0000, 8'h01, f_arg[7:0]};
        end
        CMD55: app_n = 1'b1;
        CMD41: begin
          if (!app_q) begin
            r1[R1_ILLEGAL] = 1'b1;
          end else if (retry_q != '0) begin
            retry_n = retry_q - RETRY_W'(1);
            r1      = 8'h01;
          end else begin
            idle_n  = 1'b0;
            ready_n = 1'b1;
            r1      = 8'h00;
          end
        end
        CMD58: begin
          long_n     = 1'b1;
          trail_data = {ready_q, HCS, OCR_RSVD, OCR_VDD_HI, OCR_VDD_LO, OCR_LOW};
        end
        CMD59: crc_on_n = f_arg[0];
        CMD17: begin
          if (idle_q) r1[R1_ILLEGAL] = 1'b1;
          else        data_n = 1'b1;
        end
        default: r1[R1_ILLEGAL] = 1'b1;
      endcase
    end
  end

  always_comb begin
    byte_limit = '0;
    case (state_q)
      S_NCR:   byte_limit = NCR_LAST;
      S_RESP:  byte_limit = resp_long_q ? CNT_W'(4) : '0;
      S_NAC:   byte_limit = NAC_LAST;
      S_DATA:  byte_limit = BLK_LAST;
      S_CRC:   byte_limit = CNT_W'(1);
      default: byte_limit = '0;
    endcase
  end

  always_comb begin
    state_next = state_q;
    if (cs_hi) begin
      state_next = S_WAIT;
    end else begin
      case (state_q)
        S_WAIT: if (start_det) state_next = S_RX;
        S_RX:   if (frame_done) state_next = frame_ok ? S_NCR : S_WAIT;
        S_NCR:  if (byte_done && byte_last) state_next = S_RESP;
        S_RESP: if (byte_done && byte_last) state_next = data_phase_q ? S_NAC : S_WAIT;
        S_NAC:  if (byte_done && byte_last) state_next = S_TOK;
        S_TOK:  if (byte_done) state_next = S_DATA;
        S_DATA: if (byte_done && byte_last) state_next = S_CRC;
        S_CRC:  if (byte_done && byte_last) state_next = S_WAIT;
        default: state_next = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) state_q <= S_WAIT;
    else           state_q <= state_next;
  end

  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      sclk_ff       <= 2'b00;
      cs_ff         <= 2'b11;
      mosi_ff       <= 2'b11;
      sclk_d        <= 1'b0;
      rx_sr         <= '1;
      rx_cnt        <= '0;
      tx_sr         <= FILL_BYTE;
      tx_bit        <= '0;
      byte_cnt      <= '0;
      resp_buf      <= '0;
      resp_long_q   <= 1'b0;
      data_phase_q  <= 1'b0;
      load_pending  <= 1'b0;
      idle_q        <= 1'b1;
      ready_q       <= 1'b0;
      crc_on_q      <= 1'b0;
      app_q         <= 1'b0;
      retry_q       <= RETRY_INIT;
      sd_miso_o     <= 1'b1;
      sd_rdreq_o    <= 1'b0;
      sd_cmdvalid_o <= 1'b0;
      sd_cmd_o      <= '0;
      sd_arg_o      <= '0;
    end else begin
      sclk_ff       <= {sclk_ff[0], sd_sclk_i};
      cs_ff         <= {cs_ff[0], sd_cs_n_i};
      mosi_ff       <= {mosi_ff[0], sd_mosi_i};
      sclk_d        <= sclk_ff[1];
      sd_cmdvalid_o <= 1'b0;
      sd_rdreq_o    <= 1'b0;
      if (cs_hi) begin
        sd_miso_o    <= 1'b1;
        rx_sr        <= '1;
        rx_cnt       <= '0;
        tx_bit       <= '0;
        byte_cnt     <= '0;
        load_pending <= 1'b0;
      end else begin
        if (sclk_rise && !tx_state) rx_sr <= {rx_sr[45:0], mosi_s};
        if (start_det)                           rx_cnt <= 6'd1;
        else if ((state_q == S_RX) && sclk_rise) rx_cnt <= rx_cnt + 6'd1;

        if (frame_done && frame_ok) begin
          sd_cmd_o      <= f_cmd;
          sd_arg_o      <= f_arg;
          sd_cmdvalid_o <= 1'b1;
          idle_q        <= idle_n;
          ready_q       <= ready_n;
          crc_on_q      <= crc_on_n;
          retry_q       <= retry_n;
          app_q         <= app_n;
          resp_buf      <= {r1, trail_data};
          resp_long_q   <= long_n;
          data_phase_q  <= data_n;
          tx_sr         <= FILL_BYTE;
          tx_bit        <= '0;
          byte_cnt      <= '0;
        end

        // The last bit of a response stays on MISO until the master samples it
        if (sclk_fall && !tx_state) sd_miso_o <= 1'b1;
        if (sclk_fall && tx_state) begin
          sd_miso_o <= tx_sr[7];
          tx_sr     <= {tx_sr[6:0], 1'b1};
          tx_bit    <= tx_bit + 3'd1;
        end

        if (byte_done) begin
          byte_cnt <= (state_next != state_q) ? '0 : byte_cnt + CNT_W'(1);
          case (state_next)
            S_RESP: begin
              tx_sr    <= (state_q == S_NCR) ? resp_buf[39:32] : resp_buf[31:24];
              if (state_q == S_RESP) resp_buf <= {resp_buf[31:0], 8'h00};
            end
            S_TOK:  tx_sr      <= DATA_TOKEN;
            S_DATA: sd_rdreq_o <= 1'b1;
            S_NCR, S_NAC, S_CRC: tx_sr <= FILL_BYTE;
            default: ;
          endcase
        end

        // Source byte is valid the cycle after the request
        load_pending <= sd_rdreq_o;
        if (load_pending) tx_sr <= sd_rddata_i;
      end
    end
  end

  assign sd_idle_o  = idle_q;
  assign sd_ready_o = ready_q;

endmodule
